cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Transmit end of the common data bus (CDB). Collects completed results (ROB tag + value) from functional units, buffers them per unit, and broadcasts exactly one result per cycle on cdb_valid/cdb_tag/cdb_value. Reservation stations and the ROB snoop this bus. It sits between the FU writeback ports and every CDB consumer, and honours the pipeline flush.

Parameters:
NUM_FU, 3, number of functional-unit result sources (0=ALU, 1=MUL, 2=LSU by convention)
FIFO_DEPTH, 2, result entries buffered per source; power of two, at least 2
TAG_W, 5, ROB tag width; tag 0 reserved as "no tag"
DATA_W, 32, result value width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
flush  input  1  mispredict flush; drops all buffered and in-flight results
fu_valid  input  NUM_FU  per-source result valid
fu_ready  output  NUM_FU  per-source buffer has space
fu_tag  input  NUM_FU x TAG_W  per-source ROB tag
fu_value  input  NUM_FU x DATA_W  per-source result value
cdb_valid  output  1  broadcast valid
cdb_tag  output  TAG_W  broadcast ROB tag
cdb_value  output  DATA_W  broadcast value
cdb_src  output  $clog2(NUM_FU)  index of the source that won this broadcast

Behaviour:
- Reset (rst=1 at posedge): all FIFOs empty; RR pointer=0; cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0. fu_ready becomes all-ones in the following cycle.
- Handshake: fu_ready[i] = !full[i], derived from registered occupancy only, with no combinational path from fu_valid. A push happens when fu_valid[i] && fu_ready[i] at posedge. Once fu_ready is low, a full FIFO accepts no push, even in a cycle where it is also popped.
- Tag 0 input: accepted (handshake completes) but discarded, never written to the FIFO.
- FIFOs: per-source circular buffer with read/write pointers and wrap-around at FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
- Arbitration:
  - Each cycle, candidates are the non-empty FIFO heads as of the registered state. Results pushed this cycle are not eligible this cycle.
  - Round-robin search starts at the RR pointer. On a grant to source g, the head is popped and the RR pointer becomes (g+1) mod NUM_FU. With no candidate, the pointer holds.
- Output register: the winner's tag/value/src are registered onto the cdb_* outputs at the same posedge as the pop, with cdb_valid=1. With no winner, cdb_valid=0 and tag/value/src hold their last values.
- Latency: a result pushed at edge N into an empty FIFO with no contention appears on the CDB during the cycle after edge N+1 (2-edge minimum). At most one broadcast per cycle.
- Flush (flush=1 at posedge):
  - All FIFOs are emptied and the RR pointer resets to 0.
  - Pushes in that cycle are dropped.
  - No pop/grant is performed, and cdb_valid=0 next cycle.
  - A broadcast already on the bus in the flush cycle stays visible for that cycle only.
- Simultaneous rst and flush: behave as rst.
- Reset or flush mid-burst: pending results are lost with no partial broadcast, and the next broadcast requires a fresh push.
- No backpressure from CDB consumers; every broadcast is fire-and-forget.

Optional Feature:
CDB_FIXED_PRIO_EN:
- Defined: arbitration is fixed priority, with the lowest source index winning. The RR pointer is removed and cdb_src favours source 0 (ALU).
- Undefined (default): round-robin as above, which guarantees each non-empty source a grant within NUM_FU cycles.

Decomposition:
- Package cdb_pkg holds TAG_W/DATA_W constants, the NO_TAG=0 constant, and the cdb_msg_t packed struct {tag, value}. Reservation stations and the ROB import the same struct.
- One sub-module, cdb_src_fifo: a single-source FIFO with push/pop, full/empty, and head data, instantiated NUM_FU times.
- Arbiter and output register stay in cdb_arbiter.

Test Plan:
1. Reset, then ALU pushes tag=1, value=10 at edge N -> cdb_valid=1, tag=1, value=10, src=0 after edge N+1; cdb_valid=0 the cycle after.
2. All three FUs push in the same cycle (tags 2, 3, 4) -> broadcasts on three consecutive cycles in order src 0, 1, 2. A second identical burst is ordered starting from the pointer (0 again after wrap), so no source is granted twice in a row while another is pending.
3. MUL pushes tags 5, 6 on back-to-back cycles with DEPTH=2 while ALU floods -> fu_ready[1]=0 after the second push. Both 5 and 6 are broadcast within 4 cycles; fu_ready[1] returns to 1.
4. Load FIFOs with tags 7, 8, 9, then assert flush for one cycle -> cdb_valid=0 for all subsequent cycles; tags 7-9 are never broadcast; fu_ready all 1.
5. Push tag=0 from LSU -> fu_ready stays 1; cdb_valid never asserts for it.
6. With CDB_FIXED_PRIO_EN, ALU and MUL push continuously -> every broadcast has cdb_src=0 while the ALU FIFO is non-empty.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB types and constants, imported by the arbiter and by every CDB consumer
// (reservation stations, ROB).
package cdb_pkg;

   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;

   localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b0}};

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
   } cdb_msg_t;

   // Index width for n sources; never below one bit.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU writeback ports and CDB broadcast bundled as one interface.
// The master side is the FU/consumer environment; the slave side is cdb_arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_FU = 3
);
   import cdb_pkg::*;

   localparam int SRC_W = src_w(NUM_FU);

   logic [NUM_FU-1:0]             fu_valid;
   logic [NUM_FU-1:0]             fu_ready;
   logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
   logic [NUM_FU-1:0][DATA_W-1:0] fu_value;
   logic                          cdb_valid;
   logic [TAG_W-1:0]              cdb_tag;
   logic [DATA_W-1:0]             cdb_value;
   logic [SRC_W-1:0]              cdb_src;

   modport master (
      output fu_valid, fu_tag, fu_value,
      input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
   );

   modport slave (
      input  fu_valid, fu_tag, fu_value,
      output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
   );

endinterface

// File: rtl/cdb_src_fifo.sv
// Single-source result FIFO: circular buffer with wrap-around pointers and an
// occupancy counter; i_clr (flush) empties it like a reset.
module cdb_src_fifo
   import cdb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_clr,
   input  logic     i_push,
   input  cdb_msg_t i_push_data,
   input  logic     i_pop,
   output logic     o_full,
   output logic     o_empty,
   output cdb_msg_t o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   cdb_msg_t         r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
   endfunction

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == {CNT_W{1'b0}});
   assign o_head    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_rd_ptr <= {PTR_W{1'b0}};
         r_wr_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop_ok)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-FU result FIFOs, one registered broadcast per cycle.
// Round-robin by default; define CDB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_FU     = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);

   localparam int SRC_W = src_w(NUM_FU);

   logic     [NUM_FU-1:0] w_full;
   logic     [NUM_FU-1:0] w_empty;
   logic     [NUM_FU-1:0] w_push;
   logic     [NUM_FU-1:0] w_pop;
   cdb_msg_t [NUM_FU-1:0] w_in;
   cdb_msg_t [NUM_FU-1:0] w_head;
   logic                  w_grant;
   logic     [SRC_W-1:0]  w_gnt_idx;

   logic                  r_cdb_valid;
   logic     [TAG_W-1:0]  r_cdb_tag;
   logic     [DATA_W-1:0] r_cdb_value;
   logic     [SRC_W-1:0]  r_cdb_src;

   // NO_TAG results complete the handshake but are never stored.
   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
      assign w_in[gi]   = '{tag: bus.fu_tag[gi], value: bus.fu_value[gi]};
      assign w_push[gi] = bus.fu_valid[gi] && !w_full[gi] && !flush
                          && (bus.fu_tag[gi] != NO_TAG);
      assign w_pop[gi]  = w_grant && !flush && (w_gnt_idx == SRC_W'(gi));

      cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk         (clk),
         .rst         (rst),
         .i_clr       (flush),
         .i_push      (w_push[gi]),
         .i_push_data (w_in[gi]),
         .i_pop       (w_pop[gi]),
         .o_full      (w_full[gi]),
         .o_empty     (w_empty[gi]),
         .o_head      (w_head[gi])
      );
   end

   assign bus.fu_ready = ~w_full;

`ifdef CDB_FIXED_PRIO_EN
   always_comb begin
      w_grant   = 1'b0;
      w_gnt_idx = {SRC_W{1'b0}};
      for (int k = 0; k < NUM_FU; k++) begin
         if (!w_grant && !w_empty[k]) begin
            w_grant   = 1'b1;
            w_gnt_idx = SRC_W'(k);
         end else begin
            w_grant   = w_grant;
         end
      end
   end
`else
   logic [SRC_W-1:0] r_rr_ptr;

   always_comb begin
      int idx;
      w_grant   = 1'b0;
      w_gnt_idx = {SRC_W{1'b0}};
      idx       = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         else               idx = idx;
         if (!w_grant && !w_empty[idx]) begin
            w_grant   = 1'b1;
            w_gnt_idx = SRC_W'(idx);
         end else begin
            w_grant   = w_grant;
         end
      end
   end

   // Pointer moves past the winner so the same source cannot win twice while others wait.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rr_ptr <= {SRC_W{1'b0}};
      end else if (w_grant) begin
         r_rr_ptr <= (w_gnt_idx == SRC_W'(NUM_FU - 1)) ? {SRC_W{1'b0}}
                                                       : w_gnt_idx + SRC_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= {TAG_W{1'b0}};
         r_cdb_value <= {DATA_W{1'b0}};
         r_cdb_src   <= {SRC_W{1'b0}};
      end else if (flush || !w_grant) begin
         r_cdb_valid <= 1'b0;
      end else begin
         r_cdb_valid <= 1'b1;
         r_cdb_tag   <= w_head[w_gnt_idx].tag;
         r_cdb_value <= w_head[w_gnt_idx].value;
         r_cdb_src   <= w_gnt_idx;
      end
   end

   assign bus.cdb_valid = r_cdb_valid;
   assign bus.cdb_tag   = r_cdb_tag;
   assign bus.cdb_value = r_cdb_value;
   assign bus.cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: accepted results are queued per source as they are
// driven, and popped in arbitration order when the DUT broadcasts.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int NUM_FU = 3;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   cdb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

   cdb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   cdb_msg_t         sbq [NUM_FU][$];
   int               ptr;
   logic             exp_v;
   logic [TAG_W-1:0] exp_t;
   logic [31:0]      exp_val;
   int               exp_s;
   logic [31:0]      seen;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [31:0] val);
      bus.fu_valid[i] = v;
      bus.fu_tag[i]   = t;
      bus.fu_value[i] = val;
   endtask

   task automatic idle_all();
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b0, '0, 32'd0);
   endtask

   // One clock edge: advance the reference model with the current inputs, then compare.
   task automatic tick();
      logic [NUM_FU-1:0] rdy;
      int g;
      int idx;
      cdb_msg_t m;
      for (int i = 0; i < NUM_FU; i++) rdy[i] = (sbq[i].size() < DEPTH);
      if (rst || flush) begin
         for (int i = 0; i < NUM_FU; i++) sbq[i].delete();
         ptr   = 0;
         exp_v = 1'b0;
         if (rst) begin
            exp_t   = '0;
            exp_val = 32'd0;
            exp_s   = 0;
         end
      end else begin
         g = -1;
         for (int k = 0; k < NUM_FU; k++) begin
`ifdef CDB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (ptr + k) % NUM_FU;
`endif
            if (g < 0 && sbq[idx].size() > 0) g = idx;
         end
         exp_v = (g >= 0);
         if (g >= 0) begin
            m       = sbq[g].pop_front();
            exp_t   = m.tag;
            exp_val = m.value;
            exp_s   = g;
            ptr     = (g + 1) % NUM_FU;
         end
         for (int i = 0; i < NUM_FU; i++)
            if (bus.fu_valid[i] && rdy[i] && bus.fu_tag[i] != '0)
               sbq[i].push_back('{tag: bus.fu_tag[i], value: bus.fu_value[i]});
      end
      @(posedge clk);
      #1;
      check_eq("cdb_valid", 64'(bus.cdb_valid), 64'(exp_v));
      check_eq("cdb_tag",   64'(bus.cdb_tag),   64'(exp_t));
      check_eq("cdb_value", 64'(bus.cdb_value), 64'(exp_val));
      check_eq("cdb_src",   64'(bus.cdb_src),   64'(exp_s));
      for (int i = 0; i < NUM_FU; i++) rdy[i] = (sbq[i].size() < DEPTH);
      check_eq("fu_ready",  64'(bus.fu_ready),  64'(rdy));
      if (bus.cdb_valid) seen[bus.cdb_tag] = 1'b1;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      idle_all();
      ptr = 0; exp_v = 1'b0; exp_t = '0; exp_val = 32'd0; exp_s = 0; seen = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // single ALU result: visible after the second edge, gone on the third
      set_fu(0, 1'b1, 5'd1, 32'd10);
      tick();
      idle_all();
      tick();
      check_eq("t1_tag", 64'(bus.cdb_tag), 64'd1);
      check_eq("t1_value", 64'(bus.cdb_value), 64'd10);
      tick();
      check_eq("t1_valid_off", 64'(bus.cdb_valid), 64'd0);

      // two identical three-source bursts
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, 5'(2 + i), 32'(100 * b + i));
         tick();
         idle_all();
         for (int c = 0; c < 4; c++) tick();
      end

      // MUL back-to-back into a depth-2 FIFO while ALU floods
      seen = 32'd0;
      set_fu(0, 1'b1, 5'd20, 32'hA000);
      set_fu(1, 1'b1, 5'd5, 32'h5555);
      tick();
      set_fu(0, 1'b1, 5'd21, 32'hA001);
      set_fu(1, 1'b1, 5'd6, 32'h6666);
      tick();
      set_fu(1, 1'b0, '0, 32'd0);
      for (int c = 0; c < 4; c++) begin
         set_fu(0, 1'b1, 5'(22 + c), 32'(32'hA002 + c));
         tick();
      end
      idle_all();
      for (int c = 0; c < 8; c++) tick();
      check_eq("t3_seen5", 64'(seen[5]), 64'd1);
      check_eq("t3_seen6", 64'(seen[6]), 64'd1);

      // load 7,8,9 then flush before any of them can win
      seen = 32'd0;
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, 5'(7 + i), 32'(700 + i));
      tick();
      idle_all();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      check_eq("t4_dropped", 64'(seen[9:7]), 64'd0);

      // tag 0 from LSU is swallowed
      seen = 32'd0;
      set_fu(2, 1'b1, 5'd0, 32'hDEAD);
      for (int c = 0; c < 3; c++) tick();
      idle_all();
      for (int c = 0; c < 3; c++) tick();
      check_eq("t5_no_tag0", 64'(seen[0]), 64'd0);

      // ALU and MUL push continuously
      for (int c = 0; c < 10; c++) begin
         set_fu(0, 1'b1, 5'(10 + (c % 5)), $urandom);
         set_fu(1, 1'b1, 5'(15 + (c % 5)), $urandom);
         tick();
      end
      idle_all();
      for (int c = 0; c < 6; c++) tick();

      // random traffic with occasional flush and one mid-burst reset
      for (int c = 0; c < 120; c++) begin
         for (int i = 0; i < NUM_FU; i++)
            set_fu(i, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom);
         flush = ($urandom_range(15, 0) == 0);
         rst   = (c == 60);
         tick();
      end
      rst   = 1'b0;
      flush = 1'b0;
      idle_all();
      for (int c = 0; c < 8; c++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
